// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned WORD_BYTES           = 4;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decode-side controls and results.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;

    logic [31:0] instr;
    logic [31:0] instr_pc4;
    logic [15:0] imm16;
    logic        instr_valid;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, instr, instr_pc4, imm16, instr_valid, fetch_err,
        input  imem_ack, imem_rdata, stall, branch_taken, branch_offset, jump, jump_index
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc4, imm16, instr_valid, fetch_err,
        output imem_ack, imem_rdata, stall, branch_taken, branch_offset, jump, jump_index
    );

endinterface

// File: rtl/if_fetch_unit_pc_target_gen.sv
// Redirect target for the held instruction; a jump takes precedence over a taken branch.
module pc_target_gen
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] instr_pc4,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] next_redirect_pc,
    output logic        redirect
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign jump_target   = {instr_pc4[31:28], jump_index, 2'b00};
    // Offset is a word count; the sum wraps modulo 2^32.
    assign branch_target = instr_pc4 + (branch_offset << 2);

    assign redirect         = jump | branch_taken;
    assign next_redirect_pc = jump ? jump_target : branch_target;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch with timeout, held instruction for decode.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned MAX_WAIT     = 16
) (
    input logic            clk,
    input logic            rst,
    if_fetch_unit_if.master bus
);

    localparam int unsigned           CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [31:0]           WORD_INC = 32'(WORD_BYTES);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] redirect_pc;
    logic        redirect;

    pc_target_gen u_target (
        .instr_pc4       (pc4_q),
        .branch_offset   (bus.branch_offset),
        .jump_index      (bus.jump_index),
        .jump            (bus.jump),
        .branch_taken    (bus.branch_taken),
        .next_redirect_pc(redirect_pc),
        .redirect        (redirect)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    pc4_d   = pc_q + WORD_INC;
                    pc_d    = pc_q + WORD_INC;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // A redirect counts as consumption even while decode stalls.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!bus.stall) begin
                    state_d = S_REQ;
                end
            end
            S_ERR: state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
            pc4_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request, valid and error decode straight from state so reset drops them immediately.
    assign bus.imem_req    = (state_q == S_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc4   = pc4_q;
    assign bus.imm16       = instr_q[15:0];
    assign bus.instr_valid = (state_q == S_HOLD);
    assign bus.fetch_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model with scoreboards on fetch addresses and held instructions.
module tb_if_fetch_unit;

    logic clk;
    logic rst;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .MAX_WAIT    (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_exp_t;

    typedef struct {
        logic        jump;
        logic [25:0] jidx;
        logic        br;
        logic [31:0] off;
        logic        stall;
        logic [31:0] exp_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_q[$];
    fetch_exp_t  exp_q[$];
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_addr  = 32'h0;
    int          ack_delay  = 0;
    int          mwait      = 0;

    vec_t vecs[11];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2408_000A;
        if (a == 32'h4) return 32'h2409_FFFF;
        return {a[15:0] ^ 16'h8C00, a[31:16] ^ 16'h00C3};
    endfunction

    // Observe outputs, then play the memory for the coming cycle.
    task automatic step();
        fetch_exp_t e;
        logic [31:0] ea;
        logic [31:0] ei;
        @(posedge clk);
        #1;
        if (bus.imem_req && !prev_req) begin
            if (addr_q.size() == 0) begin
                check32("unexpected_req", bus.imem_addr, 32'hXXXX_XXXX);
            end else begin
                ea = addr_q.pop_front();
                check32("fetch_addr", bus.imem_addr, ea);
            end
            held_addr = bus.imem_addr;
        end else if (bus.imem_req && prev_req) begin
            check32("req_addr_stable", bus.imem_addr, held_addr);
        end
        if (bus.instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check32("unexpected_valid", bus.instr, 32'hXXXX_XXXX);
            end else begin
                e  = exp_q.pop_front();
                ei = e.instr;
                check32("instr", bus.instr, ei);
                check32("instr_pc4", bus.instr_pc4, e.pc4);
                check32("imm16", {16'h0, bus.imm16}, {16'h0, ei[15:0]});
            end
        end
        prev_req   = bus.imem_req;
        prev_valid = bus.instr_valid;

        if (!bus.imem_req) begin
            bus.imem_ack = 1'b0;
            mwait        = 0;
        end else if (mwait >= ack_delay) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
            e.instr        = bus.imem_rdata;
            e.pc4          = bus.imem_addr + 32'd4;
            exp_q.push_back(e);
            mwait          = 0;
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            mwait++;
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.instr_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) check32({name, "_valid_timeout"}, 32'(bus.instr_valid), 32'h1);
    endtask

    task automatic consume();
        bus.stall = 1'b0;
        step();
        bus.stall = 1'b1;
    endtask

    initial begin
        logic [31:0] saved;
        int n;

        vecs[0]  = '{1'b1, 26'h000_003F, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_00FC};
        vecs[1]  = '{1'b0, 26'h000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0000_00F8};
        vecs[2]  = '{1'b0, 26'h000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_00FC};
        vecs[3]  = '{1'b0, 26'h000_0000, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0000_00F8};
        vecs[4]  = '{1'b1, 26'h000_003F, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_00FC};
        vecs[5]  = '{1'b0, 26'h000_0000, 1'b1, 32'h0FFF_FFC3, 1'b0, 32'h4000_000C};
        vecs[6]  = '{1'b1, 26'h000_0040, 1'b1, 32'h0000_0005, 1'b1, 32'h4000_0100};
        vecs[7]  = '{1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h4000_0104};
        vecs[8]  = '{1'b0, 26'h000_0000, 1'b1, 32'h2FFF_FFBD, 1'b0, 32'hFFFF_FFFC};
        vecs[9]  = '{1'b0, 26'h000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[10] = '{1'b1, 26'h3FF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 32'h0FFF_FFFC};

        rst               = 1'b1;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_index    = 26'h0;

        // Reset and boot with a zero-wait memory.
        step(); step(); step();
        check32("rst_req", 32'(bus.imem_req), 32'h0);
        check32("rst_addr", bus.imem_addr, 32'h0);
        check32("rst_valid", 32'(bus.instr_valid), 32'h0);
        check32("rst_err", 32'(bus.fetch_err), 32'h0);
        check32("rst_instr", bus.instr, 32'h0);
        check32("rst_pc4", bus.instr_pc4, 32'h0);
        addr_q.push_back(32'h0);
        ack_delay = 0;
        rst = 1'b0;
        check32("boot_no_req", 32'(bus.imem_req), 32'h0);
        step();
        check32("boot_req", 32'(bus.imem_req), 32'h1);
        step();
        check32("boot_valid", 32'(bus.instr_valid), 32'h1);
        check32("boot_imm16", {16'h0, bus.imm16}, 32'h0000_000A);

        // Sequential fetch with a 2-cycle ack delay.
        ack_delay = 2;
        addr_q.push_back(32'h4);
        consume();
        wait_valid("seq");
        check32("seq_imm16", {16'h0, bus.imm16}, 32'h0000_FFFF);

        // Stall holds the instruction for 5 cycles.
        saved = bus.instr;
        for (int i = 0; i < 5; i++) begin
            step();
            check32($sformatf("stall_valid_%0d", i), 32'(bus.instr_valid), 32'h1);
            check32($sformatf("stall_instr_%0d", i), bus.instr, saved);
            check32($sformatf("stall_req_%0d", i), 32'(bus.imem_req), 32'h0);
        end
        addr_q.push_back(32'h8);
        consume();
        wait_valid("post_stall");

        // Redirect / consume table applied to the held instruction.
        for (int i = 0; i < 11; i++) begin
            wait_valid($sformatf("vec%0d", i));
            ack_delay = i % 3;
            addr_q.push_back(vecs[i].exp_addr);
            bus.jump          = vecs[i].jump;
            bus.jump_index    = vecs[i].jidx;
            bus.branch_taken  = vecs[i].br;
            bus.branch_offset = vecs[i].off;
            bus.stall         = vecs[i].stall;
            step();
            check32($sformatf("vec%0d_consumed", i), 32'(bus.instr_valid), 32'h0);
            bus.jump         = 1'b0;
            bus.branch_taken = 1'b0;
            bus.stall        = 1'b1;
        end
        wait_valid("table_end");

        // Reset asserted mid-wait drops the request asynchronously.
        ack_delay = 255;
        rst = 1'b1;
        step(); step();
        addr_q.push_back(32'h0);
        rst = 1'b0;
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        check32("async_req_drop", 32'(bus.imem_req), 32'h0);
        check32("async_err_clear", 32'(bus.fetch_err), 32'h0);
        step(); step();
        check32("async_err_held_clear", 32'(bus.fetch_err), 32'h0);

        // Timeout with MAX_WAIT=4 and no ack.
        addr_q.push_back(32'h0);
        rst = 1'b0;
        step();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.fetch_err) break;
            if (bus.imem_req) n++;
            step();
        end
        check32("timeout_req_cycles", 32'(n), 32'd4);
        check32("timeout_err", 32'(bus.fetch_err), 32'h1);
        bus.jump = 1'b1;
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check32($sformatf("err_stuck_req_%0d", i), 32'(bus.imem_req), 32'h0);
            check32($sformatf("err_stuck_flag_%0d", i), 32'(bus.fetch_err), 32'h1);
            check32($sformatf("err_stuck_valid_%0d", i), 32'(bus.instr_valid), 32'h0);
        end

        check32("addr_queue_drained", 32'(addr_q.size()), 32'h0);
        check32("instr_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
